// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Owns the PC, issues one request at a time to instruction memory over a
// req/gnt/rvalid handshake, predicts with a direct-mapped BTB of 2-bit
// counters, takes redirects from execute and hands instructions to decode
// through a valid/ready register slice.
module fetch_unit #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int unsigned      BTB_IDX  = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_pred_taken,
    output logic [XLEN-1:0] out_pred_tgt,
    input  logic            ex_upd,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_redirect_pc
);

    localparam int unsigned     BTB_N      = 1 << BTB_IDX;
    localparam int unsigned     TAG_W      = XLEN - BTB_IDX - 2;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(1));

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_KILL = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic            fpred_taken_q, fpred_taken_d;
    logic [XLEN-1:0] fpred_tgt_q, fpred_tgt_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic            out_pred_taken_q, out_pred_taken_d;
    logic [XLEN-1:0] out_pred_tgt_q, out_pred_tgt_d;

    logic [BTB_N-1:0] btb_valid_q, btb_valid_d;
    logic [TAG_W-1:0] btb_tag_q [BTB_N];
    logic [TAG_W-1:0] btb_tag_d [BTB_N];
    logic [XLEN-1:0]  btb_tgt_q [BTB_N];
    logic [XLEN-1:0]  btb_tgt_d [BTB_N];
    logic [1:0]       btb_ctr_q [BTB_N];
    logic [1:0]       btb_ctr_d [BTB_N];

    logic [BTB_IDX-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;
    logic               lk_taken;
    logic [XLEN-1:0]    lk_next;

    logic [BTB_IDX-1:0] up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;

    // The two low bits of the resolved PC never select a BTB entry.
    logic unused_ex_pc_bits;
    assign unused_ex_pc_bits = ^ex_pc[1:0];

    // BTB lookup on the current PC and the resulting predicted next PC.
    always_comb begin
        lk_idx   = pc_q[BTB_IDX+1:2];
        lk_tag   = pc_q[XLEN-1:BTB_IDX+2];
        lk_hit   = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit && btb_ctr_q[lk_idx][1];
        lk_next  = lk_taken ? btb_tgt_q[lk_idx] : (pc_q + PC_STEP);
    end

    // Fetch FSM and output slice next state; a redirect overrides the normal flow.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        fpc_d            = fpc_q;
        fpred_taken_d    = fpred_taken_q;
        fpred_tgt_d      = fpred_tgt_q;
        out_valid_d      = out_valid_q;
        out_instr_d      = out_instr_q;
        out_pc_d         = out_pc_q;
        out_pred_taken_d = out_pred_taken_q;
        out_pred_tgt_d   = out_pred_tgt_q;

        case (state_q)
            S_REQ: begin
                if (imem_gnt) begin
                    fpc_d         = pc_q;
                    fpred_taken_d = lk_taken;
                    fpred_tgt_d   = lk_next;
                    pc_d          = lk_next;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid && !ex_redirect) begin
                    out_instr_d      = imem_rdata;
                    out_pc_d         = fpc_q;
                    out_pred_taken_d = fpred_taken_q;
                    out_pred_tgt_d   = fpred_tgt_q;
                    out_valid_d      = 1'b1;
                    state_d          = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_REQ;
                end
            end
            default: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
        endcase

        // A stale response arriving with the redirect retires the outstanding
        // request, so only a still-pending request leaves us in S_KILL.
        if (ex_redirect) begin
            pc_d        = ex_redirect_pc & ALIGN_MASK;
            out_valid_d = 1'b0;
            case (state_q)
                S_REQ:   state_d = imem_gnt ? S_KILL : S_REQ;
                S_WAIT:  state_d = imem_rvalid ? S_REQ : S_KILL;
                S_HOLD:  state_d = S_REQ;
                default: state_d = imem_rvalid ? S_REQ : S_KILL;
            endcase
        end
    end

    // BTB training from execute: counter update on hit, allocate on taken miss.
    always_comb begin
        btb_valid_d = btb_valid_q;
        btb_tag_d   = btb_tag_q;
        btb_tgt_d   = btb_tgt_q;
        btb_ctr_d   = btb_ctr_q;
        up_idx      = ex_pc[BTB_IDX+1:2];
        up_tag      = ex_pc[XLEN-1:BTB_IDX+2];
        up_hit      = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

        if (ex_upd) begin
            if (up_hit) begin
                if (ex_taken) begin
                    if (btb_ctr_q[up_idx] != 2'b11) begin
                        btb_ctr_d[up_idx] = btb_ctr_q[up_idx] + 2'b01;
                    end
                    btb_tgt_d[up_idx] = ex_target;
                end else if (btb_ctr_q[up_idx] != 2'b00) begin
                    btb_ctr_d[up_idx] = btb_ctr_q[up_idx] - 2'b01;
                end
            end else if (ex_taken) begin
                btb_valid_d[up_idx] = 1'b1;
                btb_tag_d[up_idx]   = up_tag;
                btb_tgt_d[up_idx]   = ex_target;
                btb_ctr_d[up_idx]   = 2'b10;
            end
        end
    end

    // Fetch state, PC and output slice registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= S_REQ;
            pc_q             <= RESET_PC;
            fpc_q            <= '0;
            fpred_taken_q    <= 1'b0;
            fpred_tgt_q      <= '0;
            out_valid_q      <= 1'b0;
            out_instr_q      <= '0;
            out_pc_q         <= '0;
            out_pred_taken_q <= 1'b0;
            out_pred_tgt_q   <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            fpc_q            <= fpc_d;
            fpred_taken_q    <= fpred_taken_d;
            fpred_tgt_q      <= fpred_tgt_d;
            out_valid_q      <= out_valid_d;
            out_instr_q      <= out_instr_d;
            out_pc_q         <= out_pc_d;
            out_pred_taken_q <= out_pred_taken_d;
            out_pred_tgt_q   <= out_pred_tgt_d;
        end
    end

    // BTB storage; counters restart weakly not-taken.
    always_ff @(posedge clk) begin
        if (!reset) begin
            btb_valid_q <= '0;
            for (int i = 0; i < BTB_N; i++) begin
                btb_tag_q[i] <= '0;
                btb_tgt_q[i] <= '0;
                btb_ctr_q[i] <= 2'b01;
            end
        end else begin
            btb_valid_q <= btb_valid_d;
            btb_tag_q   <= btb_tag_d;
            btb_tgt_q   <= btb_tgt_d;
            btb_ctr_q   <= btb_ctr_d;
        end
    end

    assign imem_req       = reset && (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign out_valid      = out_valid_q;
    assign out_instr      = out_instr_q;
    assign out_pc         = out_pc_q;
    assign out_pred_taken = out_pred_taken_q;
    assign out_pred_tgt   = out_pred_tgt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an instruction-memory
// responder and a scoreboard that checks every instruction handed to decode.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_pred_taken;
    logic [31:0] out_pred_tgt;
    logic        ex_upd;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_redirect;
    logic [31:0] ex_redirect_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Memory responder controls and state.
    int          gnt_hold  = 0;
    int          rsp_extra = 0;
    logic        rsp_pending = 1'b0;
    int          rsp_cnt = 0;
    logic [31:0] rsp_addr = '0;

    // Free-running clock.
    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .BTB_IDX  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pred_taken (out_pred_taken),
        .out_pred_tgt   (out_pred_tgt),
        .ex_upd         (ex_upd),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_redirect    (ex_redirect),
        .ex_redirect_pc (ex_redirect_pc)
    );

    // Instruction word the memory returns for an address.
    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of execute-side traffic.
    task automatic applyStimulus(input logic upd, input logic [31:0] upd_pc,
                                 input logic taken, input logic [31:0] tgt,
                                 input logic redir, input logic [31:0] redir_pc);
        ex_upd         = upd;
        ex_pc          = upd_pc;
        ex_taken       = taken;
        ex_target      = tgt;
        ex_redirect    = redir;
        ex_redirect_pc = redir_pc;
        tick();
        ex_upd         = 1'b0;
        ex_taken       = 1'b0;
        ex_redirect    = 1'b0;
    endtask

    task automatic expectOut(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        exp_t e;
        e.pc    = pc;
        e.instr = instrOf(pc);
        e.taken = taken;
        e.tgt   = tgt;
        exp_q.push_back(e);
    endtask

    // Let decode accept until all expected instructions are seen, then stall it.
    task automatic drain(input string name);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s_drain: got %0d outputs pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        out_ready = 1'b0;
    endtask

    // Instruction memory: grants after gnt_hold requesting cycles, answers
    // rsp_extra cycles after the cycle following the grant.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (rsp_pending && rsp_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instrOf(rsp_addr);
                rsp_pending = 1'b0;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
                if (rsp_pending) rsp_cnt--;
            end
            imem_gnt = imem_req && (gnt_hold == 0);
            if (imem_req && gnt_hold > 0) gnt_hold--;
            if (imem_gnt) begin
                rsp_pending = 1'b1;
                rsp_cnt     = rsp_extra;
                rsp_addr    = imem_addr;
            end
        end
    end

    // Scoreboard monitor: every accepted instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_out: got pc %h, required no output", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("sb_pc", out_pc, mon_e.pc);
                checkOutput("sb_instr", out_instr, mon_e.instr);
                checkOutput("sb_pred_taken", 32'(out_pred_taken), 32'(mon_e.taken));
                checkOutput("sb_pred_tgt", out_pred_tgt, mon_e.tgt);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        int n;
        reset          = 1'b0;
        out_ready      = 1'b1;
        ex_upd         = 1'b0;
        ex_pc          = '0;
        ex_taken       = 1'b0;
        ex_target      = '0;
        ex_redirect    = 1'b0;
        ex_redirect_pc = '0;

        // 1: reset, then sequential fetch from RESET_PC
        tick();
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_pc", out_pc, 32'd0);
        checkOutput("rst_instr", out_instr, 32'd0);
        checkOutput("rst_pred_taken", 32'(out_pred_taken), 32'd0);
        checkOutput("rst_pred_tgt", out_pred_tgt, 32'd0);
        tick();
        reset = 1'b1;
        #1;
        checkOutput("t1_first_addr", imem_addr, 32'h0);
        checkOutput("t1_first_req", 32'(imem_req), 32'd1);
        expectOut(32'h0, 1'b0, 32'h4);
        expectOut(32'h4, 1'b0, 32'h8);
        expectOut(32'h8, 1'b0, 32'hC);
        drain("t1");

        // 2: allocate 0x10 -> 0x40 and refetch through it
        applyStimulus(1'b1, 32'h10, 1'b1, 32'h40, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8);
        expectOut(32'h8,  1'b0, 32'hC);
        expectOut(32'hC,  1'b0, 32'h10);
        expectOut(32'h10, 1'b1, 32'h40);
        expectOut(32'h40, 1'b0, 32'h44);
        drain("t2");

        // 3: four not-taken saturate at 00, one taken gives 01 (still not-taken)
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        applyStimulus(1'b1, 32'h10, 1'b1, 32'h80, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hC);
        expectOut(32'hC,  1'b0, 32'h10);
        expectOut(32'h10, 1'b0, 32'h14);
        expectOut(32'h14, 1'b0, 32'h18);
        drain("t3a");
        applyStimulus(1'b1, 32'h10, 1'b1, 32'h80, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h10);
        expectOut(32'h10, 1'b1, 32'h80);
        expectOut(32'h80, 1'b0, 32'h84);
        drain("t3b");

        // 4: redirect while waiting on a slow response; stale data is dropped
        rsp_extra = 3;
        n = 0;
        do begin
            tick();
            n++;
        end while (imem_req && n < 20);
        checkOutput("t4_in_wait", 32'(imem_req), 32'd0);
        out_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1001);
        n = 0;
        while (!imem_req && n < 20) begin
            checkOutput("t4_no_valid", 32'(out_valid), 32'd0);
            tick();
            n++;
        end
        checkOutput("t4_redirect_addr", imem_addr, 32'h1000);
        checkOutput("t4_redirect_req", 32'(imem_req), 32'd1);
        rsp_extra = 0;
        expectOut(32'h1000, 1'b0, 32'h1004);
        expectOut(32'h1004, 1'b0, 32'h1008);
        drain("t4");

        // 5: decode stalls for 5 cycles, then accepts exactly one
        expectOut(32'h1008, 1'b0, 32'h100C);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("t5_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("t5_hold_pc", out_pc, 32'h1008);
            checkOutput("t5_hold_instr", out_instr, 32'hC0DE_1008);
            checkOutput("t5_hold_req", 32'(imem_req), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("t5_one_hs", 32'(exp_q.size()), 32'd0);
        checkOutput("t5_valid_drop", 32'(out_valid), 32'd0);

        // 6: grant stalled 3 cycles, then reset while waiting on the response
        gnt_hold  = 3;
        rsp_extra = 2;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t6_stall_addr", imem_addr, 32'h100C);
            checkOutput("t6_stall_req", 32'(imem_req), 32'd1);
            tick();
        end
        checkOutput("t6_in_wait", 32'(imem_req), 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("t6_rst_req", 32'(imem_req), 32'd0);
        checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("t6_rst_valid2", 32'(out_valid), 32'd0);
        reset     = 1'b1;
        rsp_extra = 0;
        #1;
        checkOutput("t6_rst_addr", imem_addr, 32'h0);
        checkOutput("t6_rst_req_on", 32'(imem_req), 32'd1);
        expectOut(32'h0,  1'b0, 32'h4);
        expectOut(32'h4,  1'b0, 32'h8);
        expectOut(32'h8,  1'b0, 32'hC);
        expectOut(32'hC,  1'b0, 32'h10);
        expectOut(32'h10, 1'b0, 32'h14);
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
